regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of write-back requesters; index 0 is ALU, 1 is load unit, 2 is extra unit.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive lost cycles after which a requester is promoted; legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rest  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  NUM_REQ  per-requester write request.
REQ-006 req_addr  in  4*NUM_REQ  destination register per requester (slice i = bits 4i+3:4i).
REQ-007 req_data  in  16*NUM_REQ  write data per requester.
REQ-008 req_ready  out  NUM_REQ  grant; one-hot or zero, combinational from current state and req_valid.
REQ-009 wr_en  out  1  register-file write enable (drives RegWrite).
REQ-010 wr_addr  out  4  register-file WriteRegister.
REQ-011 wr_data  out  16  register-file WriteData.
REQ-012 rsv_valid  in  1  issue stage reserves a destination register.
REQ-013 rsv_addr  in  4  register being reserved.
REQ-014 src1_addr, src2_addr  in  4 each  issue-stage source operands.
REQ-015 flush  in  1  synchronous clear of all reservations.
REQ-016 hazard  out  1  combinational stall request to issue stage.
REQ-017 busy_mask  out  16  registered reservation bits, bit n = register n.
REQ-018 drop_err  out  1  one-cycle pulse: accepted write targeted a protected register.

Function
REQ-019 Handshake: transfer occurs in the cycle req_valid[i] and req_ready[i] are both 1; requester holds valid, addr and data stable until then.
REQ-020 At most one req_ready bit is 1 per cycle; req_ready[i] is never 1 while req_valid[i] is 0.
REQ-021 Default priority is fixed: lowest index wins.
REQ-022 Each requester has a 4-bit wait counter: increments (saturating at 15) each cycle it is valid and not granted; clears on grant or when not valid.
REQ-023 A requester with wait counter >= STARVE_LIMIT is starved; starved requesters beat all non-starved ones; among several starved, lowest index wins.
REQ-024 Latency: grant in cycle N -> wr_en=1, wr_addr, wr_data valid in cycle N+1 (registered), for exactly one cycle.
REQ-025 Protected registers 0, 9, 12, 13: the write is accepted (req_ready=1) but wr_en stays 0 in N+1, and drop_err pulses in N+1.
REQ-026 No grant in cycle N -> wr_en=0 in N+1; wr_addr/wr_data hold their previous values.
REQ-027 Scoreboard set: rsv_valid=1 with rsv_addr non-protected and not busy -> busy_mask[rsv_addr]=1 next cycle.
REQ-028 Scoreboard clear: a write issued on wr_en=1 clears busy_mask[wr_addr] next cycle.
REQ-029 Same register set and cleared in the same cycle: set wins (busy stays 1).
REQ-030 rsv_valid to a protected register: no reservation, no hazard from that address.
REQ-031 hazard = busy[src1_addr] | busy[src2_addr] | (rsv_valid & busy[rsv_addr]); register 0 never busy.
REQ-032 Reservation to an already-busy register: ignored (bit unchanged); hazard=1 requires the issue stage to retry.
REQ-033 flush=1: all busy bits clear next cycle and set/clear requests that cycle are ignored; arbitration and the wr_* pipeline continue unaffected.

Reset
REQ-034 rest=0 immediately forces wr_en=0, wr_addr=0, wr_data=0, drop_err=0, busy_mask=0, all wait counters=0; req_ready and hazard therefore read 0 while asserted.
REQ-035 A write granted in the cycle rest asserts is lost; no partial write reaches the register file.
REQ-036 Release of rest is synchronised by the system; the block resumes arbitration on the first posedge after release.

Structure
REQ-037 Package regfile_pkg holds REG_W=16, ADDR_W=4, NUM_REGS=16 and protected indices R_ZERO=0, R_SR=9, R_HI=12, R_LO=13, shared with the register file.
REQ-038 Scoreboard (busy bits, set/clear/flush, hazard) is one sub-module, wb_scoreboard; arbiter and output register stay in the top.

Verification
REQ-039 req_valid=3'b011, addr0=1, addr1=2 -> cycle N ready=001; N+1 wr_en=1, wr_addr=1; N+1 ready=010; N+2 wr_addr=2.
REQ-040 req0 held valid continuously, req2 valid, STARVE_LIMIT=4 -> req2 granted on its 5th cycle of waiting, then req0 resumes.
REQ-041 Single request addr=12 data=16'hBEEF -> ready=1, next cycle wr_en=0, drop_err=1.
REQ-042 rsv_valid addr=5 -> busy_mask=16'h0020; src1_addr=5 -> hazard=1; ALU write to 5 -> busy clears the cycle after wr_en; simultaneous re-reserve of 5 keeps bit 5 set.
REQ-043 busy_mask=16'h00F0 then flush=1 with rsv_valid addr=3 -> busy_mask=0 next cycle.
REQ-044 rest asserted mid-stream with grant pending -> wr_en=0, busy_mask=0 immediately; after release, first grant follows fixed priority.

Source files
------------

// File: rtl/regfile_pkg.sv
// Register-file constants shared by the write-back arbiter, the scoreboard and
// the register file itself, including the protected register indices.
package regfile_pkg;

   localparam int REG_W    = 16;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 16;

   localparam int R_ZERO = 0;
   localparam int R_SR   = 9;
   localparam int R_HI   = 12;
   localparam int R_LO   = 13;

   localparam int WAIT_W = 4;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_W-1:0]  reg_data_t;
   typedef logic [WAIT_W-1:0] wait_cnt_t;

   localparam wait_cnt_t WAIT_MAX = '1;

   // One registered write-back slot as seen by the register file.
   typedef struct packed {
      logic      en;
      logic      drop;
      reg_addr_t addr;
      reg_data_t data;
   } wb_slot_t;

   function automatic logic is_protected(input reg_addr_t a);
      return (a == reg_addr_t'(R_ZERO)) || (a == reg_addr_t'(R_SR)) ||
             (a == reg_addr_t'(R_HI))   || (a == reg_addr_t'(R_LO));
   endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Destination-register reservation bits: set by the issue stage, cleared by
// register-file writes, bulk-cleared by flush; produces the issue stall.
module wb_scoreboard
   import regfile_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                rsv_valid_i,
   input  reg_addr_t           rsv_addr_i,
   input  reg_addr_t           src1_addr_i,
   input  reg_addr_t           src2_addr_i,
   input  logic                flush_i,
   input  logic                clr_en_i,
   input  reg_addr_t           clr_addr_i,
   output logic                hazard_o,
   output logic [NUM_REGS-1:0] busy_o
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic                clr_hit;
   logic                set_ok;

   // A reservation to a register whose write is retiring this cycle is
   // accepted, so the new owner's bit survives the clear.
   always_comb begin
      clr_hit = clr_en_i && (clr_addr_i == rsv_addr_i);
      set_ok  = rsv_valid_i && !is_protected(rsv_addr_i) &&
                (!busy_q[rsv_addr_i] || clr_hit);
      busy_d  = busy_q;
      if (clr_en_i) begin
         busy_d[clr_addr_i] = 1'b0;
      end
      if (set_ok) begin
         busy_d[rsv_addr_i] = 1'b1;
      end
      if (flush_i) begin
         busy_d = '0;
      end
      busy_d[R_ZERO] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   always_comb begin
      hazard_o = busy_q[src1_addr_i] | busy_q[src2_addr_i] |
                 (rsv_valid_i & busy_q[rsv_addr_i]);
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register-file write port: fixed priority with
// starvation promotion, one-cycle registered write, protected-register drop.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ      = 3,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                      clk,
   input  logic                      rest,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
   input  logic [REG_W*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [REG_W-1:0]          wr_data,
   input  logic                      rsv_valid,
   input  logic [ADDR_W-1:0]         rsv_addr,
   input  logic [ADDR_W-1:0]         src1_addr,
   input  logic [ADDR_W-1:0]         src2_addr,
   input  logic                      flush,
   output logic                      hazard,
   output logic [NUM_REGS-1:0]       busy_mask,
   output logic                      drop_err
);

   // Handshake: a write transfers in the cycle req_valid[i] and req_ready[i]
   // are both high; the requester holds valid, addr and data until then.

   localparam wait_cnt_t STARVE_TH = wait_cnt_t'(STARVE_LIMIT);

   logic [NUM_REQ-1:0] starved;
   logic [NUM_REQ-1:0] cand;
   logic [NUM_REQ-1:0] grant;
   logic               grant_any;
   reg_addr_t          sel_addr;
   reg_data_t          sel_data;
   wait_cnt_t          wait_q [NUM_REQ];
   wait_cnt_t          wait_d [NUM_REQ];
   wb_slot_t           wb_q;
   wb_slot_t           wb_d;

   // Starved requesters form the candidate set when any exist; the lowest
   // set bit of the candidate set wins.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         starved[i] = req_valid[i] && (wait_q[i] >= STARVE_TH);
      end
      cand  = (|starved) ? starved : req_valid;
      grant = cand & (~cand + NUM_REQ'(1));
      if (!rest) begin
         grant = '0;
      end
      grant_any = |grant;
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*REG_W +: REG_W];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && !grant[i]) begin
            wait_d[i] = (wait_q[i] == WAIT_MAX) ? wait_q[i]
                                                : wait_q[i] + wait_cnt_t'(1);
         end else begin
            wait_d[i] = '0;
         end
      end
   end

   // Address and data hold when nothing is granted; a protected target is
   // consumed but reported through drop instead of the write enable.
   always_comb begin
      wb_d      = wb_q;
      wb_d.en   = 1'b0;
      wb_d.drop = 1'b0;
      if (grant_any) begin
         wb_d.addr = sel_addr;
         wb_d.data = sel_data;
         wb_d.en   = !is_protected(sel_addr);
         wb_d.drop = is_protected(sel_addr);
      end
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         wb_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            wait_q[i] <= '0;
         end
      end else begin
         wb_q <= wb_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            wait_q[i] <= wait_d[i];
         end
      end
   end

   wb_scoreboard u_scoreboard (
      .clk_i       (clk),
      .rst_ni      (rest),
      .rsv_valid_i (rsv_valid),
      .rsv_addr_i  (rsv_addr),
      .src1_addr_i (src1_addr),
      .src2_addr_i (src2_addr),
      .flush_i     (flush),
      .clr_en_i    (wb_q.en),
      .clr_addr_i  (wb_q.addr),
      .hazard_o    (hazard),
      .busy_o      (busy_mask)
   );

   assign req_ready = grant;
   assign wr_en     = wb_q.en;
   assign wr_addr   = wb_q.addr;
   assign wr_data   = wb_q.data;
   assign drop_err  = wb_q.drop;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle vector table plus
// hand-written starvation and mid-stream reset sequences.
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rest;
   logic [2:0]  req_valid;
   logic [11:0] req_addr;
   logic [47:0] req_data;
   logic [2:0]  req_ready;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        rsv_valid;
   logic [3:0]  rsv_addr;
   logic [3:0]  src1_addr;
   logic [3:0]  src2_addr;
   logic        flush;
   logic        hazard;
   logic [15:0] busy_mask;
   logic        drop_err;

   int checks = 0;
   int errors = 0;

   regfile_wb_arbiter #(.NUM_REQ(3), .STARVE_LIMIT(4)) dut (
      .clk       (clk),
      .rest      (rest),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .src1_addr (src1_addr),
      .src2_addr (src2_addr),
      .flush     (flush),
      .hazard    (hazard),
      .busy_mask (busy_mask),
      .drop_err  (drop_err)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One record per cycle: inputs driven after posedge, outputs sampled at
   // negedge. Registered outputs reflect the previous cycle's grant.
   typedef struct {
      string       name;
      logic [2:0]  val;
      logic [11:0] addr;
      logic [47:0] data;
      logic        rv;
      logic [3:0]  ra;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic        fl;
      logic [2:0]  er;
      logic        ewe;
      logic        chk;
      logic [3:0]  ewa;
      logic [15:0] ewd;
      logic        edrop;
      logic [15:0] ebusy;
      logic        ehaz;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input string n, input int val,
                               input int a0, input int a1, input int a2,
                               input int d0, input int d1, input int d2,
                               input int rv, input int ra, input int s1,
                               input int s2, input int fl, input int er,
                               input int ewe, input int chk, input int ewa,
                               input int ewd, input int edrop, input int ebusy,
                               input int ehaz);
      vec_t v;
      v.name  = n;
      v.val   = 3'(val);
      v.addr  = {4'(a2), 4'(a1), 4'(a0)};
      v.data  = {16'(d2), 16'(d1), 16'(d0)};
      v.rv    = 1'(rv);
      v.ra    = 4'(ra);
      v.s1    = 4'(s1);
      v.s2    = 4'(s2);
      v.fl    = 1'(fl);
      v.er    = 3'(er);
      v.ewe   = 1'(ewe);
      v.chk   = 1'(chk);
      v.ewa   = 4'(ewa);
      v.ewd   = 16'(ewd);
      v.edrop = 1'(edrop);
      v.ebusy = 16'(ebusy);
      v.ehaz  = 1'(ehaz);
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      rsv_valid = 1'b0;
      rsv_addr  = '0;
      src1_addr = '0;
      src2_addr = '0;
      flush     = 1'b0;
   endtask

   task automatic drive_vec(input vec_t v);
      req_valid = v.val;
      req_addr  = v.addr;
      req_data  = v.data;
      rsv_valid = v.rv;
      rsv_addr  = v.ra;
      src1_addr = v.s1;
      src2_addr = v.s2;
      flush     = v.fl;
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic check_vec(input vec_t v);
      check({v.name, ".ready"},  64'(req_ready), 64'(v.er));
      check({v.name, ".wr_en"},  64'(wr_en),     64'(v.ewe));
      check({v.name, ".drop"},   64'(drop_err),  64'(v.edrop));
      check({v.name, ".busy"},   64'(busy_mask), 64'(v.ebusy));
      check({v.name, ".hazard"}, 64'(hazard),    64'(v.ehaz));
      if (v.chk) begin
         check({v.name, ".wr_addr"}, 64'(wr_addr), 64'(v.ewa));
         check({v.name, ".wr_data"}, 64'(wr_data), 64'(v.ewd));
      end
   endtask

   // ---------------- test ----------------
   initial begin
      //            name         val    a0 a1 a2 d0       d1       d2       rv ra s1 s2 fl er     we ck wa wd       dr busy     hz
      tbl.push_back(mk("p_both",    'b011, 1, 2, 0, 'h1111, 'h2222, 0,       0, 0, 0, 0, 0, 'b001, 0, 1, 0, 'h0000, 0, 'h0000, 0));
      tbl.push_back(mk("p_second",  'b010, 1, 2, 0, 'h1111, 'h2222, 0,       0, 0, 0, 0, 0, 'b010, 1, 1, 1, 'h1111, 0, 'h0000, 0));
      tbl.push_back(mk("p_wr2",     'b000, 0, 0, 0, 0,      0,      0,       0, 0, 0, 0, 0, 'b000, 1, 1, 2, 'h2222, 0, 'h0000, 0));
      tbl.push_back(mk("p_hold",    'b000, 0, 0, 0, 0,      0,      0,       0, 0, 0, 0, 0, 'b000, 0, 1, 2, 'h2222, 0, 'h0000, 0));
      tbl.push_back(mk("prot_req",  'b001, 12,0, 0, 'hBEEF, 0,      0,       0, 0, 0, 0, 0, 'b001, 0, 1, 2, 'h2222, 0, 'h0000, 0));
      tbl.push_back(mk("prot_drop", 'b000, 0, 0, 0, 0,      0,      0,       0, 0, 0, 0, 0, 'b000, 0, 0, 0, 0,      1, 'h0000, 0));
      tbl.push_back(mk("prot_end",  'b000, 0, 0, 0, 0,      0,      0,       0, 0, 0, 0, 0, 'b000, 0, 0, 0, 0,      0, 'h0000, 0));
      tbl.push_back(mk("rsv5",      'b000, 0, 0, 0, 0,      0,      0,       1, 5, 0, 0, 0, 'b000, 0, 0, 0, 0,      0, 'h0000, 0));
      tbl.push_back(mk("src1_5",    'b000, 0, 0, 0, 0,      0,      0,       0, 0, 5, 0, 0, 'b000, 0, 0, 0, 0,      0, 'h0020, 1));
      tbl.push_back(mk("alu_wr5",   'b001, 5, 0, 0, 'h5555, 0,      0,       0, 0, 0, 0, 0, 'b001, 0, 0, 0, 0,      0, 'h0020, 0));
      tbl.push_back(mk("wr5",       'b000, 0, 0, 0, 0,      0,      0,       0, 0, 0, 0, 0, 'b000, 1, 1, 5, 'h5555, 0, 'h0020, 0));
      tbl.push_back(mk("clr5",      'b000, 0, 0, 0, 0,      0,      0,       0, 0, 0, 0, 0, 'b000, 0, 1, 5, 'h5555, 0, 'h0000, 0));
      tbl.push_back(mk("rersv5",    'b000, 0, 0, 0, 0,      0,      0,       1, 5, 0, 0, 0, 'b000, 0, 1, 5, 'h5555, 0, 'h0000, 0));
      tbl.push_back(mk("alu_wr5b",  'b001, 5, 0, 0, 'h0A0A, 0,      0,       0, 0, 0, 0, 0, 'b001, 0, 1, 5, 'h5555, 0, 'h0020, 0));
      tbl.push_back(mk("set_wins",  'b000, 0, 0, 0, 0,      0,      0,       1, 5, 0, 0, 0, 'b000, 1, 1, 5, 'h0A0A, 0, 'h0020, 1));
      tbl.push_back(mk("rsv4",      'b000, 0, 0, 0, 0,      0,      0,       1, 4, 0, 0, 0, 'b000, 0, 1, 5, 'h0A0A, 0, 'h0020, 0));
      tbl.push_back(mk("rsv6",      'b000, 0, 0, 0, 0,      0,      0,       1, 6, 0, 0, 0, 'b000, 0, 1, 5, 'h0A0A, 0, 'h0030, 0));
      tbl.push_back(mk("rsv7",      'b000, 0, 0, 0, 0,      0,      0,       1, 7, 0, 0, 0, 'b000, 0, 1, 5, 'h0A0A, 0, 'h0070, 0));
      tbl.push_back(mk("flush",     'b010, 0, 3, 0, 0,      'h3333, 0,       1, 3, 0, 0, 1, 'b010, 0, 1, 5, 'h0A0A, 0, 'h00F0, 0));
      tbl.push_back(mk("flushed",   'b000, 0, 0, 0, 0,      0,      0,       0, 0, 0, 0, 0, 'b000, 1, 1, 3, 'h3333, 0, 'h0000, 0));
      tbl.push_back(mk("post_fl",   'b000, 0, 0, 0, 0,      0,      0,       0, 0, 0, 0, 0, 'b000, 0, 1, 3, 'h3333, 0, 'h0000, 0));
      tbl.push_back(mk("rsv_prot",  'b000, 0, 0, 0, 0,      0,      0,       1, 9, 0, 9, 0, 'b000, 0, 1, 3, 'h3333, 0, 'h0000, 0));
      tbl.push_back(mk("rsv8",      'b000, 0, 0, 0, 0,      0,      0,       1, 8, 0, 0, 0, 'b000, 0, 1, 3, 'h3333, 0, 'h0000, 0));
      tbl.push_back(mk("rsv8_again",'b000, 0, 0, 0, 0,      0,      0,       1, 8, 0, 0, 0, 'b000, 0, 1, 3, 'h3333, 0, 'h0100, 1));
      tbl.push_back(mk("src2_8",    'b000, 0, 0, 0, 0,      0,      0,       0, 0, 0, 8, 0, 'b000, 0, 1, 3, 'h3333, 0, 'h0100, 1));
      tbl.push_back(mk("flush2",    'b000, 0, 0, 0, 0,      0,      0,       0, 0, 0, 0, 1, 'b000, 0, 1, 3, 'h3333, 0, 'h0100, 0));
      tbl.push_back(mk("pri_12",    'b110, 0, 7, 8, 0,      'h7777, 'h8888,  0, 0, 0, 0, 0, 'b010, 0, 1, 3, 'h3333, 0, 'h0000, 0));
      tbl.push_back(mk("pri_2",     'b100, 0, 0, 8, 0,      0,      'h8888,  0, 0, 0, 0, 0, 'b100, 1, 1, 7, 'h7777, 0, 'h0000, 0));
      tbl.push_back(mk("pri_wr2",   'b000, 0, 0, 0, 0,      0,      0,       0, 0, 0, 0, 0, 'b000, 1, 1, 8, 'h8888, 0, 'h0000, 0));
      tbl.push_back(mk("pri_all",   'b111, 1, 2, 3, 'hA001, 'hA002, 'hA003,  0, 0, 0, 0, 0, 'b001, 0, 1, 8, 'h8888, 0, 'h0000, 0));
      tbl.push_back(mk("pri_wr0",   'b000, 0, 0, 0, 0,      0,      0,       0, 0, 0, 0, 0, 'b000, 1, 1, 1, 'hA001, 0, 'h0000, 0));

      // Reset state, with requests and a reservation pending during reset.
      rest = 1'b0;
      drive_idle();
      req_valid = 3'b111;
      rsv_valid = 1'b1;
      rsv_addr  = 4'd5;
      @(negedge clk);
      check("rst.ready",   64'(req_ready), 64'(0));
      check("rst.wr_en",   64'(wr_en),     64'(0));
      check("rst.wr_addr", 64'(wr_addr),   64'(0));
      check("rst.wr_data", 64'(wr_data),   64'(0));
      check("rst.drop",    64'(drop_err),  64'(0));
      check("rst.busy",    64'(busy_mask), 64'(0));
      check("rst.hazard",  64'(hazard),    64'(0));
      @(negedge clk);
      drive_idle();
      rest = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk);
         #1;
         drive_vec(tbl[i]);
         @(negedge clk);
         check_vec(tbl[i]);
      end

      // Starvation: req0 stays valid, req2 waits; promoted on 5th waiting cycle.
      for (int w = 1; w <= 7; w++) begin
         @(posedge clk);
         #1;
         drive_idle();
         req_valid = (w <= 5) ? 3'b101 : 3'b001;
         req_addr  = {4'd2, 4'd0, 4'd1};
         req_data  = {16'h2002, 16'h0000, 16'h1001};
         @(negedge clk);
         check($sformatf("starve.w%0d.ready", w), 64'(req_ready),
               64'((w == 5) ? 3'b100 : 3'b001));
         if (w == 6) begin
            check("starve.wr_addr", 64'(wr_addr), 64'(2));
            check("starve.wr_data", 64'(wr_data), 64'(16'h2002));
         end
      end

      // Mid-stream reset with a grant pending and a busy bit set.
      @(posedge clk);
      #1;
      drive_idle();
      req_valid = 3'b001;
      req_addr  = {4'd0, 4'd0, 4'd6};
      req_data  = {16'h0, 16'h0, 16'h6666};
      rsv_valid = 1'b1;
      rsv_addr  = 4'd10;
      @(negedge clk);
      check("mrst.pre_ready", 64'(req_ready), 64'(3'b001));
      @(posedge clk);
      #1;
      drive_idle();
      req_valid = 3'b001;
      req_addr  = {4'd0, 4'd0, 4'd11};
      req_data  = {16'h0, 16'h0, 16'hBBBB};
      src1_addr = 4'd10;
      @(negedge clk);
      check("mrst.pre_wr_en",  64'(wr_en),     64'(1));
      check("mrst.pre_wr_addr",64'(wr_addr),   64'(6));
      check("mrst.pre_busy",   64'(busy_mask), 64'(16'h0400));
      check("mrst.pre_hazard", 64'(hazard),    64'(1));
      rest = 1'b0;
      #1;
      check("mrst.wr_en",   64'(wr_en),     64'(0));
      check("mrst.wr_addr", 64'(wr_addr),   64'(0));
      check("mrst.wr_data", 64'(wr_data),   64'(0));
      check("mrst.busy",    64'(busy_mask), 64'(0));
      check("mrst.ready",   64'(req_ready), 64'(0));
      check("mrst.hazard",  64'(hazard),    64'(0));
      @(posedge clk);
      #1;
      check("mrst.lost_wr_en",   64'(wr_en),   64'(0));
      check("mrst.lost_wr_data", 64'(wr_data), 64'(0));
      @(negedge clk);
      drive_idle();
      req_valid = 3'b011;
      req_addr  = {4'd0, 4'd5, 4'd4};
      req_data  = {16'h0, 16'h5555, 16'h4444};
      rest = 1'b1;
      #1;
      check("mrst.first_ready", 64'(req_ready), 64'(3'b001));
      @(posedge clk);
      #1;
      req_valid = 3'b010;
      @(negedge clk);
      check("mrst.first_wr_en",   64'(wr_en),     64'(1));
      check("mrst.first_wr_addr", 64'(wr_addr),   64'(4));
      check("mrst.first_wr_data", 64'(wr_data),   64'(16'h4444));
      check("mrst.second_ready",  64'(req_ready), 64'(3'b010));

      @(posedge clk);
      #1;
      drive_idle();
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
